// File: rtl/moonbase_pdp8_memif.sv
// Bus slave for the moonbase PDP-8 multiplexed CPU bus: decodes address/IO/data
// beats, serves read nibbles from a word array, commits writes, bridges IO cycles.
module moonbase_pdp8_memif #(
    parameter int          DEPTH_LOG2 = 6,
    parameter logic [11:0] WINDOW     = 12'o0200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  bus_in,
    output logic [3:0]  cpu_din,
    input  logic        irq,
    output logic [5:0]  io_dev,
    output logic [2:0]  io_fn,
    output logic [11:0] io_wdata,
    output logic        io_wr_stb,
    output logic        io_rd_stb,
    input  logic [11:0] io_rdata,
    input  logic        io_ready,
    input  logic        io_skip,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [11:0] ld_addr,
    input  logic [11:0] ld_data,
    output logic        proto_err
);

    localparam logic [2:0] S_LO = 3'd0;
    localparam logic [2:0] S_HI = 3'd1;
    localparam logic [2:0] S_D0 = 3'd2;
    localparam logic [2:0] S_D1 = 3'd3;
    localparam logic [2:0] S_D2 = 3'd4;

    logic [2:0]  state;
    logic [11:0] addr;
    logic        is_io;
    logic        dir;
    logic [7:0]  wbuf;
    logic [11:0] rbuf;
    logic        irq_s1, irq_s2;
    logic [11:0] mem [2**DEPTH_LOG2];

    // 011w1fff matches neither intro nor a legal data index, so it is a violation.
    logic       is_alo, is_ahi, is_intro, is_data, bw;
    logic [1:0] idx;
    assign is_alo   = (bus_in[7:6] == 2'b10);
    assign is_ahi   = (bus_in[7:6] == 2'b11);
    assign is_intro = (bus_in[7:5] == 3'b011) && !bus_in[3];
    assign is_data  = !bus_in[7] && (bus_in[6:5] != 2'b11);
    assign idx      = bus_in[6:5];
    assign bw       = bus_in[4];

    logic        in_win, ld_in_win, fin_ok, mem_commit;
    logic [11:0] mem_word, rd_word;
    assign in_win    = (addr[11:DEPTH_LOG2] == WINDOW[11:DEPTH_LOG2]);
    assign ld_in_win = (ld_addr[11:DEPTH_LOG2] == WINDOW[11:DEPTH_LOG2]);
    assign mem_word  = in_win ? mem[addr[DEPTH_LOG2-1:0]] : 12'o0000;
    assign rd_word   = is_io ? rbuf : mem_word;

    assign fin_ok     = (state == S_D2) && is_data && (idx == 2'b10) && (bw == dir);
    assign mem_commit = reset_n && fin_ok && !is_io && dir && in_win;
    assign ld_ready   = !mem_commit;

    always_comb begin
        cpu_din = 4'h0;
        if (is_alo || is_ahi) begin
            cpu_din = {3'b0, irq_s2};
        end else if (is_intro) begin
            cpu_din = {2'b0, io_skip, io_ready};
        end else if (is_data && !bw) begin
            case (idx)
                2'b00:   cpu_din = rd_word[11:8];
                2'b01:   cpu_din = rd_word[7:4];
                default: cpu_din = rd_word[3:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_LO;
            addr      <= '0;
            is_io     <= 1'b0;
            dir       <= 1'b0;
            wbuf      <= '0;
            rbuf      <= '0;
            irq_s1    <= 1'b0;
            irq_s2    <= 1'b0;
            proto_err <= 1'b0;
            io_dev    <= '0;
            io_fn     <= '0;
            io_wdata  <= '0;
            io_wr_stb <= 1'b0;
            io_rd_stb <= 1'b0;
        end else begin
            irq_s1    <= irq;
            irq_s2    <= irq_s1;
            io_wr_stb <= 1'b0;
            io_rd_stb <= 1'b0;
            if (is_alo) begin
                addr[5:0] <= bus_in[5:0];
                is_io     <= 1'b0;
                state     <= S_HI;
                if (state != S_LO) proto_err <= 1'b1;
            end else begin
                case (state)
                    S_LO: proto_err <= 1'b1;
                    S_HI: begin
                        if (is_ahi) begin
                            addr[11:6] <= bus_in[5:0];
                            state      <= S_D0;
                        end else begin
                            proto_err <= 1'b1;
                            state     <= S_LO;
                        end
                    end
                    S_D0: begin
                        if (is_intro && !is_io) begin
                            is_io  <= 1'b1;
                            dir    <= bw;
                            io_fn  <= bus_in[2:0];
                            rbuf   <= io_rdata;
                            io_dev <= addr[5:0];
                        end else if (is_data && idx == 2'b00 && !(is_io && bw != dir)) begin
                            dir       <= bw;
                            wbuf[3:0] <= bus_in[3:0];
                            state     <= S_D1;
                        end else begin
                            proto_err <= 1'b1;
                            state     <= S_LO;
                        end
                    end
                    S_D1: begin
                        if (is_data && idx == 2'b01 && bw == dir) begin
                            wbuf[7:4] <= bus_in[3:0];
                            state     <= S_D2;
                        end else begin
                            proto_err <= 1'b1;
                            state     <= S_LO;
                        end
                    end
                    S_D2: begin
                        state <= S_LO;
                        if (!fin_ok) begin
                            proto_err <= 1'b1;
                        end else if (is_io && dir) begin
                            io_wdata  <= {bus_in[3:0], wbuf};
                            io_wr_stb <= 1'b1;
                        end else if (is_io) begin
                            io_rd_stb <= 1'b1;
                        end
                    end
                    default: state <= S_LO;
                endcase
            end
        end
    end

    // Array survives reset; CPU commits take the single write port over preload.
    always_ff @(posedge clk) begin
        if (mem_commit)
            mem[addr[DEPTH_LOG2-1:0]] <= {bus_in[3:0], wbuf};
        else if (ld_valid && ld_in_win)
            mem[ld_addr[DEPTH_LOG2-1:0]] <= ld_data;
    end

endmodule

// File: tb/tb_moonbase_pdp8_memif.sv
// Directed bench for moonbase_pdp8_memif: back-to-back bus beats with
// hand-computed nibbles, IO strobes, preload, irq sync and violation cases.
module tb_moonbase_pdp8_memif;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  bus_in = 8'h00;
    logic [3:0]  cpu_din;
    logic        irq = 1'b0;
    logic [5:0]  io_dev;
    logic [2:0]  io_fn;
    logic [11:0] io_wdata;
    logic        io_wr_stb, io_rd_stb;
    logic [11:0] io_rdata = 12'h000;
    logic        io_ready = 1'b0;
    logic        io_skip = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [11:0] ld_addr = 12'h000;
    logic [11:0] ld_data = 12'h000;
    logic        proto_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [3:0]  d_nib;
    logic        d_ldr;

    moonbase_pdp8_memif #(.DEPTH_LOG2(6), .WINDOW(12'o0200)) dut (
        .clk(clk), .reset_n(reset_n), .bus_in(bus_in), .cpu_din(cpu_din), .irq(irq),
        .io_dev(io_dev), .io_fn(io_fn), .io_wdata(io_wdata), .io_wr_stb(io_wr_stb),
        .io_rd_stb(io_rd_stb), .io_rdata(io_rdata), .io_ready(io_ready), .io_skip(io_skip),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus beat per cycle; combinational outputs sampled mid-cycle.
    task automatic beat(input logic [7:0] b);
        bus_in = b;
        @(negedge clk);
        d_nib = cpu_din;
        d_ldr = ld_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic beat_chk(input string tag, input logic [7:0] b, input logic [3:0] exp);
        beat(b);
        chk(tag, {8'h0, d_nib}, {8'h0, exp});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_perr"}, {11'h0, proto_err}, 12'h0);
        chk({tag, "_dev"},  {6'h0, io_dev},     12'h0);
        chk({tag, "_fn"},   {9'h0, io_fn},      12'h0);
        chk({tag, "_wdat"}, io_wdata,           12'h0);
        chk({tag, "_wstb"}, {11'h0, io_wr_stb}, 12'h0);
        chk({tag, "_rstb"}, {11'h0, io_rd_stb}, 12'h0);
        chk({tag, "_ldr"},  {11'h0, ld_ready},  12'h1);
    endtask

    initial begin
        // Preload during reset: 0o0200 in window, 0o4000 outside (dropped).
        reset_n  = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 12'o0200;
        ld_data  = 12'o7200;
        @(posedge clk); #1;
        ld_addr  = 12'o4000;
        ld_data  = 12'o7777;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        chk_reset_vals("rst0");
        reset_n = 1'b1;

        // Read preloaded 0o7200 = 0xE80 at 0o0200.
        beat_chk("rd200_alo", 8'h80, 4'h0);
        beat_chk("rd200_ahi", 8'hC2, 4'h0);
        beat_chk("rd200_d0",  8'h00, 4'hE);
        beat_chk("rd200_d1",  8'h20, 4'h8);
        beat_chk("rd200_d2",  8'h40, 4'h0);
        chk("rd200_perr", {11'h0, proto_err}, 12'h0);

        // Write 0o1234 = 0x29C to 0o0205, then read it back.
        beat(8'h85);
        beat(8'hC2);
        beat_chk("wr205_d0", 8'h1C, 4'h0);
        beat(8'h39);
        chk("wr205_ldr_d1", {11'h0, d_ldr}, 12'h1);
        beat(8'h52);
        chk("wr205_ldr_commit", {11'h0, d_ldr}, 12'h0);
        beat(8'h85);
        chk("rd205_ldr_after", {11'h0, d_ldr}, 12'h1);
        beat(8'hC2);
        beat_chk("rd205_d0", 8'h00, 4'h2);
        beat_chk("rd205_d1", 8'h20, 4'h9);
        beat_chk("rd205_d2", 8'h40, 4'hC);

        // IO write: dev 3, fn 4, word 0xDEF.
        beat(8'h83);
        beat(8'hC0);
        beat_chk("iow_intro", 8'h74, 4'h0);
        chk("iow_dev", {6'h0, io_dev}, 12'd3);
        chk("iow_fn",  {9'h0, io_fn},  12'd4);
        beat(8'h1F);
        beat(8'h3E);
        chk("iow_stb_early", {11'h0, io_wr_stb}, 12'h0);
        beat(8'h5D);
        chk("iow_stb",  {11'h0, io_wr_stb}, 12'h1);
        chk("iow_wdat", io_wdata, 12'hDEF);
        chk("iow_rstb", {11'h0, io_rd_stb}, 12'h0);

        // IO read of 0xABC with ready=1, skip=0.
        io_rdata = 12'hABC;
        io_ready = 1'b1;
        io_skip  = 1'b0;
        beat(8'h83);
        chk("iow_stb_single", {11'h0, io_wr_stb}, 12'h0);
        beat(8'hC0);
        beat_chk("ior_intro", 8'h61, 4'h1);
        io_rdata = 12'h123;
        beat_chk("ior_d0", 8'h00, 4'hA);
        beat_chk("ior_d1", 8'h20, 4'hB);
        beat_chk("ior_d2", 8'h40, 4'hC);
        chk("ior_stb", {11'h0, io_rd_stb}, 12'h1);
        chk("ior_fn",  {9'h0, io_fn}, 12'd1);

        // irq reaches cpu_din two edges after it rises.
        irq = 1'b1;
        beat_chk("irq_c0", 8'h80, 4'h0);
        chk("ior_stb_single", {11'h0, io_rd_stb}, 12'h0);
        beat_chk("irq_c1", 8'hC2, 4'h0);
        beat_chk("irq_rd_d0", 8'h00, 4'hE);
        beat_chk("irq_rd_d1", 8'h20, 4'h8);
        beat_chk("irq_rd_d2", 8'h40, 4'h0);
        // Out-of-window read of 0o4000.
        beat_chk("oow_alo", 8'h80, 4'h1);
        beat_chk("oow_ahi", 8'hE0, 4'h1);
        beat_chk("oow_d0",  8'h00, 4'h0);
        beat_chk("oow_d1",  8'h20, 4'h0);
        beat_chk("oow_d2",  8'h40, 4'h0);
        irq = 1'b0;
        chk("oow_perr", {11'h0, proto_err}, 12'h0);

        // Data beat in S_LO is a violation; the flag is sticky.
        beat(8'h00);
        chk("viol_perr", {11'h0, proto_err}, 12'h1);
        beat(8'h85);
        beat(8'hC2);
        beat_chk("viol_rd_d0", 8'h00, 4'h2);
        beat_chk("viol_rd_d1", 8'h20, 4'h9);
        beat_chk("viol_rd_d2", 8'h40, 4'hC);
        chk("viol_sticky", {11'h0, proto_err}, 12'h1);

        // Reset in the middle of a write to 0o0205 discards it.
        beat(8'h85);
        beat(8'hC2);
        beat(8'h17);
        reset_n = 1'b0;
        beat(8'h39);
        chk_reset_vals("rst1");
        reset_n = 1'b1;
        beat(8'h85);
        beat(8'hC2);
        beat_chk("rst_rd_d0", 8'h00, 4'h2);
        beat_chk("rst_rd_d1", 8'h20, 4'h9);
        beat_chk("rst_rd_d2", 8'h40, 4'hC);
        chk("rst_rd_perr", {11'h0, proto_err}, 12'h0);
        // After a completed cycle, a stray data beat flags again.
        beat(8'h20);
        chk("rst_viol_perr", {11'h0, proto_err}, 12'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
